// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// inst_loader : byte-stream program loader for instruction memory (big-endian word packing)
// Optional checksum byte: define INST_LOADER_CHECKSUM_EN          Rev 1.0
// ============================================================================
module inst_loader #(
  parameter int INST_ADDR_WIDTH     = 16,
  parameter int INST_DATA_BIT_WIDTH = 16,
  parameter int INST_MEM_SIZE       = 26,
  parameter int NUM_BYTES_IN_INST   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INST_ADDR_WIDTH-1:0]     len,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  output logic                           byte_ready,
  output logic                           mem_wr,
  output logic [INST_ADDR_WIDTH-1:0]     mem_addr,
  output logic [INST_DATA_BIT_WIDTH-1:0] mem_data,
  output logic                           cpu_hold,
  output logic                           done,
  output logic                           error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_HI = 3'd1;
  localparam logic [2:0] S_LOAD_LO = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd4;
`endif
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [INST_ADDR_WIDTH-1:0] c_mem_size = INST_ADDR_WIDTH'(INST_MEM_SIZE);
  localparam logic [INST_ADDR_WIDTH-1:0] c_stride   = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
  localparam logic [INST_ADDR_WIDTH-1:0] c_one      = INST_ADDR_WIDTH'(1);

  logic [2:0]                 r_state;
  logic [2:0]                 w_state_nxt;
  logic [INST_ADDR_WIDTH-1:0] r_len;
  logic [INST_ADDR_WIDTH-1:0] r_count;
  logic                       w_xfer;
  logic                       w_start_arm;
  logic                       w_load_go;
  logic                       w_last;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]                 r_xsum;
`endif

  assign w_xfer      = byte_valid && byte_ready;
  assign w_start_arm = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_load_go   = w_start_arm && (len != '0) && (len <= c_mem_size);
  assign w_last      = ((r_count + c_one) == r_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (len == '0)             w_state_nxt = S_DONE;
          else if (len > c_mem_size) w_state_nxt = S_ERR;
          else                       w_state_nxt = S_LOAD_HI;
        end
      end
      S_LOAD_HI: if (w_xfer) w_state_nxt = S_LOAD_LO;
      S_LOAD_LO: if (w_xfer) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_LOAD_HI;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_state_nxt = (byte_in == r_xsum) ? S_DONE : S_ERR;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend on state only, so byte_ready never follows byte_valid combinationally.
  always_comb begin
    byte_ready = 1'b0;
    mem_wr     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_LOAD_HI, S_LOAD_LO: byte_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK:              byte_ready = 1'b1;
`endif
      S_WRITE:              mem_wr     = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:                error      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len    <= '0;
      r_count  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (w_load_go) begin
        r_len    <= len;
        r_count  <= '0;
        mem_addr <= '0;
      end
      if ((r_state == S_LOAD_HI) && w_xfer) mem_data[INST_DATA_BIT_WIDTH-1 -: 8] <= byte_in;
      if ((r_state == S_LOAD_LO) && w_xfer) mem_data[7:0] <= byte_in;
      if (r_state == S_WRITE) begin
        mem_addr <= mem_addr + c_stride;
        r_count  <= r_count + c_one;
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xsum <= '0;
    end else if (w_load_go) begin
      r_xsum <= '0;
    end else if (((r_state == S_LOAD_HI) || (r_state == S_LOAD_LO)) && w_xfer) begin
      r_xsum <= r_xsum ^ byte_in;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/inst_loader.md
# inst_loader

Program loader that writes the instruction memory which the CPU fetch stage reads. It accepts a byte stream over a valid/ready handshake and packs byte pairs big-endian into 16-bit instruction words. Each word is written to sequential byte addresses (stride NUM_BYTES_IN_INST). The loader holds the CPU core in reset until a load completes successfully.

## Interface
- INST_ADDR_WIDTH, 16, width of instruction byte address
- INST_DATA_BIT_WIDTH, 16, instruction word width (two bytes)
- INST_MEM_SIZE, 26, instruction memory capacity in words
- NUM_BYTES_IN_INST, 2, address stride per word
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; begins a load of `len` words
- len  input  INST_ADDR_WIDTH  word count; sampled only on accepted `start`
- byte_in  input  8  stream byte
- byte_valid  input  1  `byte_in` is valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_wr  output  1  instruction memory write strobe
- mem_addr  output  INST_ADDR_WIDTH  write byte address
- mem_data  output  INST_DATA_BIT_WIDTH  write data
- cpu_hold  output  1  1 = CPU core held in reset
- done  output  1  load completed without error
- error  output  1  load aborted; sticky

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK (macro only), DONE, ERR.
- Byte transfer occurs when `byte_valid && byte_ready` are both high at a clock edge.
- IDLE:
  - `start` with `len == 0` -> DONE.
  - `start` with `len > INST_MEM_SIZE` -> ERR.
  - Otherwise latch `len`, clear word counter and address to 0 -> LOAD_HI.
- LOAD_HI: `byte_ready = 1`; on transfer, the byte goes to `mem_data[15:8]` -> LOAD_LO.
- LOAD_LO: `byte_ready = 1`; on transfer, the byte goes to `mem_data[7:0]` -> WRITE.
- WRITE:
  - `mem_wr = 1` for exactly one cycle, with the current `mem_addr` and `mem_data`.
  - Then `mem_addr += NUM_BYTES_IN_INST` and the word counter increments.
  - If the counter reaches `len`: -> CHECK if the macro is defined, else -> DONE. Otherwise -> LOAD_HI.
- DONE: `done = 1`, `cpu_hold = 0`. A new `start` re-arms the load: `cpu_hold = 1`, `done = 0`, same checks as IDLE.
- ERR: `error = 1`, `cpu_hold = 1`. Only `start` (re-evaluated as in IDLE) or `rst` leaves ERR; `error` clears on the leaving edge.
- `start` is ignored in LOAD_HI, LOAD_LO, WRITE and CHECK.
- `byte_ready = 0` in IDLE, WRITE, DONE and ERR. Bytes offered in those states are not consumed.
- Address arithmetic is modulo 2^INST_ADDR_WIDTH. The `len` check guarantees the address never exceeds `(INST_MEM_SIZE-1)*NUM_BYTES_IN_INST`.

## Timing
- Reset values (async on `rst` low): state IDLE, `byte_ready` 0, `mem_wr` 0, `mem_addr` 0, `mem_data` 0, `cpu_hold` 1, `done` 0, `error` 0.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.
- Minimum throughput: 3 cycles per word (HI accept, LO accept, WRITE) with `byte_valid` held high.
- `start` accepted at edge N:
  - `byte_ready` goes high in cycle N+1.
  - With the stream gapless, the first `mem_wr` is in cycle N+3.
- `cpu_hold` falls on the same edge that `done` rises.
- Reset mid-load aborts immediately. Partially written memory contents are left as written, and `cpu_hold` returns to 1.
- Idle stream cycles (`byte_valid = 0`) stall the FSM in LOAD_HI or LOAD_LO indefinitely; there is no timeout.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, enter CHECK with `byte_ready = 1`.
  - The accepted byte must equal the XOR of all 2·`len` payload bytes. Match -> DONE; mismatch -> ERR.
  - For `len == 0`, IDLE still goes directly to DONE; no checksum byte is expected.
- Not defined: the CHECK state and the XOR accumulator are absent; WRITE of the last word -> DONE.

## Test plan
- Reset then `start`, `len = 2`, bytes 0x12,0x34,0xAB,0xCD gapless -> writes (0x0000, 0x1234) then (0x0002, 0xABCD). `done = 1` and `cpu_hold = 0` 1 cycle after the second write.
- `start`, `len = 27` -> ERR next cycle: `error = 1`, `cpu_hold = 1`, no `mem_wr`, `byte_ready` stays 0. A following `start`, `len = 1` clears `error` and loads normally.
- `len = 26` with `byte_valid` toggling every other cycle -> 26 writes, last at `mem_addr` 0x0032, each `mem_wr` exactly one cycle. `start` pulses injected mid-load have no effect.
- `rst` low while in LOAD_LO after 3 words -> all outputs return to reset values asynchronously. A fresh load of `len = 1` then writes at 0x0000.
- With `INST_LOADER_CHECKSUM_EN`, `len = 1`, bytes 0x0F,0xF0:
  - Checksum 0xFF -> DONE.
  - Repeat with checksum 0x00 -> ERR, `cpu_hold` stays 1.
- `len = 0` -> DONE one cycle after `start`, with no `byte_ready` and no `mem_wr`.
